// File: rtl/pll_lock_supervisor.sv
// Supervises a Gowin rPLL: pulses its reset, qualifies lock, retries on timeout,
// and releases N reset domains in ascending order once lock has been stable.
module pll_lock_supervisor #(
   parameter int PLL_RESET_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int N_DOMAINS           = 2,
   parameter int STAGE_DELAY         = 64,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 17
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pll_lock,
   output logic                 pll_reset,
   output logic                 clk_locked,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic [7:0]           lock_lost_count,
   output logic                 fault
);

   localparam int SW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STAGE_DELAY - 1);
   localparam logic [SW-1:0]    LAST_STAGE = SW'(N_DOMAINS - 1);
   localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic [SW-1:0]          stage, stage_nx;
   logic [RW-1:0]          retries, retries_nx;
   logic                   sync_p0, lock_s;
   logic                   pll_reset_nx, clk_locked_nx, fault_nx;
   logic [N_DOMAINS-1:0]   rst_out_nx;
   logic [7:0]             lost_nx;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      stage_nx      = stage;
      retries_nx    = retries;
      pll_reset_nx  = pll_reset;
      clk_locked_nx = clk_locked;
      rst_out_nx    = rst_out;
      lost_nx       = lock_lost_count;
      fault_nx      = fault;

      case (state)
         S_PLL_RST: begin
            if (cnt == PR_LAST) begin
               state_nx     = S_WAIT_LOCK;
               cnt_nx       = '0;
               pll_reset_nx = 1'b0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         // Lock is checked before the timeout so a simultaneous lock wins.
         S_WAIT_LOCK: begin
            if (lock_s) begin
               cnt_nx = '0;
               if (LOCK_STABLE_CYCLES == 1) begin
                  state_nx      = S_RELEASE;
                  clk_locked_nx = 1'b1;
                  stage_nx      = '0;
               end else begin
                  state_nx = S_STABLE;
                  cnt_nx   = CNT_W'(1);
               end
            end else if (cnt == TO_LAST) begin
               retries_nx = retries + 1'b1;
               cnt_nx     = '0;
               if (retries_nx == RETRY_MAX) begin
                  state_nx = S_FAULT;
                  fault_nx = 1'b1;
               end else begin
                  state_nx     = S_PLL_RST;
                  pll_reset_nx = 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         S_STABLE: begin
            if (!lock_s) begin
               state_nx = S_WAIT_LOCK;
               cnt_nx   = '0;
            end else if (cnt == ST_LAST) begin
               state_nx      = S_RELEASE;
               clk_locked_nx = 1'b1;
               cnt_nx        = '0;
               stage_nx      = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         S_RELEASE: begin
            if (cnt == SD_LAST) begin
               rst_out_nx[stage] = 1'b0;
               cnt_nx            = '0;
               if (stage == LAST_STAGE) begin
                  state_nx   = S_RUN;
                  retries_nx = '0;
               end else begin
                  stage_nx = stage + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         S_FAULT: begin
            fault_nx     = 1'b1;
            pll_reset_nx = 1'b0;
         end

         default: ;
      endcase

      // Lock loss overrides any release step taken on the same edge.
      if ((state == S_RELEASE || state == S_RUN) && !lock_s) begin
         state_nx      = S_PLL_RST;
         cnt_nx        = '0;
         stage_nx      = '0;
         rst_out_nx    = '1;
         clk_locked_nx = 1'b0;
         pll_reset_nx  = 1'b1;
         lost_nx       = sat_inc8(lock_lost_count);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_PLL_RST;
         cnt             <= '0;
         stage           <= '0;
         retries         <= '0;
         sync_p0         <= 1'b0;
         lock_s          <= 1'b0;
         pll_reset       <= 1'b1;
         clk_locked      <= 1'b0;
         rst_out         <= '1;
         lock_lost_count <= 8'd0;
         fault           <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         stage           <= stage_nx;
         retries         <= retries_nx;
         sync_p0         <= pll_lock;
         lock_s          <= sync_p0;
         pll_reset       <= pll_reset_nx;
         clk_locked      <= clk_locked_nx;
         rst_out         <= rst_out_nx;
         lock_lost_count <= lost_nx;
         fault           <= fault_nx;
      end
   end

endmodule
